hazard_control_unit: RTL

- Centralised hazard controller for the 5-stage MIPS pipeline. Replaces the standalone forwarding unit.
- Generalises forwarding to parametrised register-address width.
- Adds load-use stall detection, a multi-cycle mult/div busy tracker that interlocks HI/LO readers, and branch-resolution flush.
- Keeps a saturating stall-cycle performance counter.
- Sits beside the ID and EX stages. Drives the PC write enable, the IF/ID write and flush, the ID/EX bubble and flush, the EX/MEM flush, and the forwarding mux selects.

---
 rtl/hazard_control_unit.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/hazard_control_unit.sv
// rtl/hazard_control_unit.sv - pipeline hazard controller: forwarding, load-use/mult-div interlock, branch flush
module hazard_control_unit #(
    parameter int REG_ADDR_W = 5,
    parameter int MULDIV_LAT = 4,
    parameter int CNT_W      = 32
) (
    input  logic                  Clk,
    input  logic                  Reset,
    input  logic [REG_ADDR_W-1:0] IDrs,
    input  logic [REG_ADDR_W-1:0] IDrt,
    input  logic                  IDUsesRt,
    input  logic                  IDIsMulDiv,
    input  logic                  IDReadsHiLo,
    input  logic [REG_ADDR_W-1:0] EXrs,
    input  logic [REG_ADDR_W-1:0] EXrt,
    input  logic [REG_ADDR_W-1:0] EXrd,
    input  logic                  EXMemRead,
    input  logic [REG_ADDR_W-1:0] MemRd,
    input  logic                  MemRegWrite,
    input  logic [REG_ADDR_W-1:0] WBrd,
    input  logic                  WBRegWrite,
    input  logic                  MemBranchTaken,
    output logic [1:0]            FwdCtrA,
    output logic [1:0]            FwdCtrB,
    output logic                  PCWrite,
    output logic                  IFIDWrite,
    output logic                  IDEXBubble,
    output logic                  IFIDFlush,
    output logic                  IDEXFlush,
    output logic                  EXMEMFlush,
    output logic                  MulDivBusy,
    output logic [CNT_W-1:0]      StallCycles
);

    // Down-counter wide enough to hold MULDIV_LAT.
    localparam int CW = $clog2(MULDIV_LAT + 1);
    localparam logic [CW-1:0] LAT_FULL = CW'(MULDIV_LAT);
    // While cnt is at or above this value the issuing op is still in EX/MEM.
    localparam logic [CW-1:0] LAT_YOUNG = CW'(MULDIV_LAT - 1);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } md_state_t;

    md_state_t       state;
    logic [CW-1:0]   cnt;

    logic [1:0]      fwd_a;
    logic [1:0]      fwd_b;
    logic            load_use;
    logic            muldiv_hazard;
    logic            stall;
    logic            issue;
    logic            cancel;

    // Operand A source select; MEM result is newer than WB, and $zero is never forwarded.
    always_comb begin
        fwd_a = 2'b00;
        if (MemRegWrite && (MemRd != '0) && (MemRd == EXrs)) begin
            fwd_a = 2'b01;
        end else if (WBRegWrite && (WBrd != '0) && (WBrd == EXrs)) begin
            fwd_a = 2'b10;
        end
    end

    // Operand B source select, same priority as operand A.
    always_comb begin
        fwd_b = 2'b00;
        if (MemRegWrite && (MemRd != '0) && (MemRd == EXrt)) begin
            fwd_b = 2'b01;
        end else if (WBRegWrite && (WBrd != '0) && (WBrd == EXrt)) begin
            fwd_b = 2'b10;
        end
    end

    // Hazard detection: a load in EX feeding ID, or a HI/LO user while mult/div is in flight.
    always_comb begin
        load_use      = EXMemRead && (EXrd != '0) &&
                        ((EXrd == IDrs) || (IDUsesRt && (EXrd == IDrt)));
        muldiv_hazard = MulDivBusy && (IDReadsHiLo || IDIsMulDiv);
        stall         = (load_use || muldiv_hazard) && !MemBranchTaken;
        issue         = IDIsMulDiv && !stall && !MemBranchTaken;
        cancel        = MemBranchTaken && (state == BUSY) && (cnt >= LAT_YOUNG);
    end

    // Pipeline control outputs; reset dominates, then branch flush, then stall.
    always_comb begin
        FwdCtrA    = fwd_a;
        FwdCtrB    = fwd_b;
        PCWrite    = 1'b1;
        IFIDWrite  = 1'b1;
        IDEXBubble = 1'b0;
        IFIDFlush  = 1'b0;
        IDEXFlush  = 1'b0;
        EXMEMFlush = 1'b0;
        if (Reset) begin
            FwdCtrA    = 2'b00;
            FwdCtrB    = 2'b00;
            PCWrite    = 1'b0;
            IFIDWrite  = 1'b0;
            IFIDFlush  = 1'b1;
            IDEXFlush  = 1'b1;
            EXMEMFlush = 1'b1;
        end else if (MemBranchTaken) begin
            IFIDFlush  = 1'b1;
            IDEXFlush  = 1'b1;
            EXMEMFlush = 1'b1;
        end else if (stall) begin
            PCWrite    = 1'b0;
            IFIDWrite  = 1'b0;
            IDEXBubble = 1'b1;
        end
    end

    // Mult/div busy tracker; a squashed young op releases the unit at once.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state      <= IDLE;
            cnt        <= '0;
            MulDivBusy <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (issue) begin
                        state      <= BUSY;
                        cnt        <= LAT_FULL;
                        MulDivBusy <= 1'b1;
                    end
                end
                BUSY: begin
                    if (cancel || (cnt <= CNT_ONE)) begin
                        state      <= IDLE;
                        cnt        <= '0;
                        MulDivBusy <= 1'b0;
                    end else begin
                        cnt        <= cnt - CNT_ONE;
                        MulDivBusy <= 1'b1;
                    end
                end
                default: begin
                    state      <= IDLE;
                    cnt        <= '0;
                    MulDivBusy <= 1'b0;
                end
            endcase
        end
    end

    // Saturating count of cycles in which the PC is held.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            StallCycles <= '0;
        end else if (!PCWrite && (StallCycles != '1)) begin
            StallCycles <= StallCycles + CNT_W'(1);
        end
    end

endmodule
